sram_arb: RTL

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sram_arb.sv
// sram_arb: arbitrates two requesters onto one single-port SRAM and adds a zero-fill sweep.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sram_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [8:0]  addr0,
  input  logic [8:0]  addr1,
  input  logic [11:0] wdata0,
  input  logic [11:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [11:0] rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic        mem_oen,
  output logic [8:0]  mem_a,
  output logic [11:0] mem_d,
  input  logic [11:0] mem_q
);

  typedef enum logic [1:0] {StIdle, StServe, StClear} state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q;
  logic [1:0]  tag1_q, tag2_q;
  logic        rvalid0_q, rvalid1_q, clr_done_q;
  logic [11:0] rdata_q, mem_d_q;
  logic [8:0]  mem_a_q;
  logic        mem_cen_q, mem_wen_q;
  logic        arb_ok, g0, g1;

  // Grants are also held off while in reset so they drop together with the registered outputs.
  assign arb_ok = rst_n && (state_q != StClear) && !clr_start;

`ifdef SRAM_ARB_RR_EN
  logic last1_q;  // set when requester 1 was granted most recently

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (arb_ok) begin
      if (req0 && req1) begin
        g0 = last1_q;
        g1 = !last1_q;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= 1'b1;
    end else if (g0 || g1) begin
      last1_q <= g1;
    end
  end
`else
  always_comb begin
    g0 = arb_ok && req0;
    g1 = arb_ok && req1 && !req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start)          state_d = StClear;
        else if (req0 || req1)  state_d = StServe;
      end
      StServe: begin
        if (clr_start)          state_d = StClear;
        else if (!req0 && !req1) state_d = StIdle;
      end
      StClear: begin
        if (cnt_q == 9'd511)    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 9'd0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_done_q <= (state_q == StClear) && (cnt_q == 9'd511);
      if (state_q == StClear) cnt_q <= cnt_q + 9'd1;
    end
  end

  // SRAM command register: sweep writes take precedence, idle cycles deselect the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cen_q <= 1'b1;
      mem_wen_q <= 1'b1;
      mem_a_q   <= 9'd0;
      mem_d_q   <= 12'd0;
    end else if (state_q == StClear) begin
      mem_cen_q <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_a_q   <= cnt_q;
      mem_d_q   <= 12'd0;
    end else if (g0) begin
      mem_cen_q <= 1'b0;
      mem_wen_q <= !we0;
      mem_a_q   <= addr0;
      mem_d_q   <= wdata0;
    end else if (g1) begin
      mem_cen_q <= 1'b0;
      mem_wen_q <= !we1;
      mem_a_q   <= addr1;
      mem_d_q   <= wdata1;
    end else begin
      mem_cen_q <= 1'b1;
      mem_wen_q <= 1'b1;
    end
  end

  // One-hot {req1, req0} read tags follow the access through the SRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_q    <= 2'b00;
      tag2_q    <= 2'b00;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= 12'd0;
    end else begin
      tag1_q    <= {g1 && !we1, g0 && !we0};
      tag2_q    <= tag1_q;
      rvalid0_q <= tag2_q[0];
      rvalid1_q <= tag2_q[1];
      if (|tag2_q) rdata_q <= mem_q;
    end
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign clr_busy = (state_q == StClear);
  assign clr_done = clr_done_q;
  assign mem_cen  = mem_cen_q;
  assign mem_wen  = mem_wen_q;
  assign mem_oen  = 1'b0;
  assign mem_a    = mem_a_q;
  assign mem_d    = mem_d_q;

endmodule
